store_align_unit: RTL

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

---
 rtl/store_align_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/store_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_align_unit: positions RISC-V store data/byte-enables on memory lanes |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module store_align_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic                  done,
  output logic                  fault
);

  localparam int NB = DATA_W / 8;
  localparam int LG = $clog2(NB);
  localparam int BW = 2 * NB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_wdata1;
  logic [NB-1:0]       r_be1;
  logic                r_cross;

  logic [LG-1:0]       w_off;
  logic [3:0]          w_size;
  logic [4:0]          w_end;
  logic                w_cross;
  logic                w_illegal;
  logic                w_reject;
  logic [2*DATA_W-1:0] w_wide;
  logic [BW-1:0]       w_bmask;
  logic [BW-1:0]       w_bepos;
  logic [ADDR_W-1:0]   w_base;

  assign req_ready = (r_state == IDLE);

  always_comb begin
    w_size = 4'd1;
    case (req_funct3[1:0])
      2'b00:   w_size = 4'd1;
      2'b01:   w_size = 4'd2;
      2'b10:   w_size = 4'd4;
      default: w_size = 4'd8;
    endcase
  end

  assign w_off     = req_addr[LG-1:0];
  assign w_end     = 5'(w_off) + 5'(w_size);
  assign w_cross   = (w_end > 5'(NB));
  assign w_illegal = req_funct3[2] | ((req_funct3[1:0] == 2'b11) && (DATA_W != 64));
  assign w_reject  = w_illegal | (w_cross && (MISALIGN_SPLIT == 0));
  assign w_base    = {req_addr[ADDR_W-1:LG], {LG{1'b0}}};

  // Double-width shifts: low half is beat0, high half is the spill into beat1.
  assign w_wide  = {{DATA_W{1'b0}}, req_data} << {w_off, 3'b000};
  assign w_bmask = (BW'(1) << w_size) - BW'(1);
  assign w_bepos = w_bmask << w_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wdata1  <= '0;
      r_be1     <= '0;
      r_cross   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_reject) begin
              fault <= 1'b1;
            end else begin
              r_state   <= SEND0;
              mem_valid <= 1'b1;
              mem_addr  <= w_base;
              mem_wdata <= w_wide[DATA_W-1:0];
              mem_be    <= w_bepos[NB-1:0];
              r_wdata1  <= w_wide[2*DATA_W-1:DATA_W];
              r_be1     <= w_bepos[BW-1:NB];
              r_cross   <= w_cross;
            end
          end
        end
        SEND0: begin
          if (mem_ready) begin
            if (r_cross) begin
              r_state   <= SEND1;
              mem_addr  <= mem_addr + ADDR_W'(NB);
              mem_wdata <= r_wdata1;
              mem_be    <= r_be1;
            end else begin
              r_state   <= IDLE;
              mem_valid <= 1'b0;
              mem_wdata <= '0;
              mem_be    <= '0;
              done      <= 1'b1;
            end
          end
        end
        SEND1: begin
          if (mem_ready) begin
            r_state   <= IDLE;
            mem_valid <= 1'b0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          mem_valid <= 1'b0;
          mem_wdata <= '0;
          mem_be    <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
